// File: rtl/pi_request_queue_if.sv
// Request bus between the Pi request queue and the 68k bus engine.
// The queue drives the head entry; the engine answers with REQ_READY.
interface pi_request_queue_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [23:0] REQ_ADDR;
  logic [31:0] REQ_WDATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_READ;
  logic [2:0]  REQ_FC;

  modport src (output REQ_VALID, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_READ, REQ_FC,
               input  REQ_READY);
  modport snk (input  REQ_VALID, REQ_ADDR, REQ_WDATA, REQ_SIZE, REQ_READ, REQ_FC,
               output REQ_READY);
endinterface

// File: rtl/pi_request_queue.sv
// Pi write strobe synchroniser, request staging registers and a DEPTH-entry
// request FIFO feeding the 68k bus engine.
module pi_request_queue #(
  parameter int         DEPTH       = 4,
  parameter logic [2:0] REG_DATA_LO = 3'd0,
  parameter logic [2:0] REG_DATA_HI = 3'd1,
  parameter logic [2:0] REG_ADDR_LO = 3'd2,
  parameter logic [2:0] REG_ADDR_HI = 3'd3,
  parameter logic [2:0] REG_CONTROL = 3'd7
) (
  input  logic                     SYSCLK,
  input  logic                     nRESET,
  input  logic                     PI_WR,
  input  logic [2:0]               PI_A,
  input  logic [15:0]              PI_D,
  input  logic                     IN_FLIGHT,
  pi_request_queue_if.src          req,
  output logic                     FULL,
  output logic                     BUSY,
  output logic                     OVERFLOW,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [23:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        rd;
    logic [2:0]  fc;
  } req_t;

  // s0 -> s1 -> s2; vld_pipe_q marks which stages hold a post-reset sample so a
  // strobe already low at reset release never looks like a falling edge.
  logic [2:0] wr_sync_q;
  logic [2:0] vld_pipe_q;
  logic       wr_ev;

  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_sync_q  <= 3'b111;
      vld_pipe_q <= 3'b000;
    end else begin
      wr_sync_q  <= {wr_sync_q[1:0], PI_WR};
      vld_pipe_q <= {vld_pipe_q[1:0], 1'b1};
    end
  end

  assign wr_ev = vld_pipe_q[2] & wr_sync_q[2] & ~wr_sync_q[1];

  req_t stage_q, stage_d;
  logic push, ovf_clr;

  always_comb begin
    stage_d = stage_q;
    push    = 1'b0;
    ovf_clr = 1'b0;
    if (wr_ev) begin
      if (PI_A == REG_DATA_LO) begin
        stage_d.wdata[15:0] = PI_D;
      end else if (PI_A == REG_DATA_HI) begin
        stage_d.wdata[31:16] = PI_D;
      end else if (PI_A == REG_ADDR_LO) begin
        stage_d.addr[15:0] = PI_D;
      end else if (PI_A == REG_ADDR_HI) begin
        stage_d.addr[23:16] = PI_D[7:0];
        stage_d.size        = PI_D[9:8];
        stage_d.rd          = PI_D[10];
        stage_d.fc          = PI_D[13:11];
        push                = 1'b1;
      end else if (PI_A == REG_CONTROL) begin
        ovf_clr = ~PI_D[15] & PI_D[3];
      end
    end
  end

  req_t          mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          pop, push_ok;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign pop     = (cnt_q != '0) & req.REQ_READY;
  assign push_ok = push & ((cnt_q != CW'(DEPTH)) | pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push_ok && pop) cnt_d = cnt_q - 1'b1;
    if (ovf_clr)          ovf_d = 1'b0;
    if (push && !push_ok) ovf_d = 1'b1;
  end

  always_ff @(posedge SYSCLK or negedge nRESET) begin
    if (!nRESET) begin
      stage_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      if (push_ok) mem_q[wptr_q] <= stage_d;
    end
  end

  assign req.REQ_VALID = (cnt_q != '0);
  assign req.REQ_ADDR  = mem_q[rptr_q].addr;
  assign req.REQ_WDATA = mem_q[rptr_q].wdata;
  assign req.REQ_SIZE  = mem_q[rptr_q].size;
  assign req.REQ_READ  = mem_q[rptr_q].rd;
  assign req.REQ_FC    = mem_q[rptr_q].fc;

  assign FULL     = (cnt_q == CW'(DEPTH));
  assign BUSY     = (cnt_q != '0) | IN_FLIGHT;
  assign OVERFLOW = ovf_q;
  assign COUNT    = cnt_q;

endmodule

// File: tb/tb_pi_request_queue.sv
// Randomised bench for pi_request_queue against a queue-based request model.
module tb_pi_request_queue;
  localparam int DEPTH = 4;

  logic        sysclk = 1'b0;
  logic        nreset = 1'b0;
  logic        pi_wr  = 1'b1;
  logic [2:0]  pi_a   = '0;
  logic [15:0] pi_d   = '0;
  logic        in_flight = 1'b0;
  logic        full, busy, ovf;
  logic [2:0]  count;

  pi_request_queue_if rq();

  always #5 sysclk = ~sysclk;

  pi_request_queue #(.DEPTH(DEPTH)) dut (
    .SYSCLK(sysclk), .nRESET(nreset), .PI_WR(pi_wr), .PI_A(pi_a), .PI_D(pi_d),
    .IN_FLIGHT(in_flight), .req(rq), .FULL(full), .BUSY(busy),
    .OVERFLOW(ovf), .COUNT(count)
  );

  typedef struct packed {
    logic [23:0] a;
    logic [31:0] w;
    logic [1:0]  s;
    logic        r;
    logic [2:0]  fc;
  } ent_t;

  int          n_vec = 0;
  int          n_err = 0;
  ent_t        mq[$];
  ent_t        stg = '0;
  bit          m_ovf = 0;
  int          pend = 0;
  logic [2:0]  pa;
  logic [15:0] pd;
  bit          prev_wr = 1;
  int          rdy_mode = 0;   // 0 low, 1 high, 2 random, 3 pulse on commit
  bit          rand_if = 0;
  bit          chk_le1 = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("valid", rq.REQ_VALID, mq.size() != 0);
    chk("count", count, mq.size());
    chk("full", full, mq.size() == DEPTH);
    chk("busy", busy, (mq.size() != 0) || in_flight);
    chk("ovf", ovf, m_ovf);
    if (mq.size() != 0) begin
      chk("h_addr", rq.REQ_ADDR, mq[0].a);
      chk("h_wdata", rq.REQ_WDATA, mq[0].w);
      chk("h_size", rq.REQ_SIZE, mq[0].s);
      chk("h_read", rq.REQ_READ, mq[0].r);
      chk("h_fc", rq.REQ_FC, mq[0].fc);
    end
    if (chk_le1) chk("cnt_le1", count <= 1, 1'b1);
  endtask

  // One SYSCLK cycle: a Pi write takes effect on the 3rd rising edge after
  // PI_WR is driven low; the model then applies pop/push/overflow rules.
  task automatic cyc();
    bit pop, push, ok, clr;
    if (prev_wr && !pi_wr) begin
      pend = 3; pa = pi_a; pd = pi_d;
    end
    prev_wr = pi_wr;
    case (rdy_mode)
      0:       rq.REQ_READY = 1'b0;
      1:       rq.REQ_READY = 1'b1;
      2:       rq.REQ_READY = 1'($urandom_range(0, 1));
      default: rq.REQ_READY = (pend == 1);
    endcase
    if (rand_if) in_flight = 1'($urandom_range(0, 1));
    pop  = (mq.size() != 0) && rq.REQ_READY;
    push = 0;
    clr  = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        case (pa)
          3'd0: stg.w[15:0]  = pd;
          3'd1: stg.w[31:16] = pd;
          3'd2: stg.a[15:0]  = pd;
          3'd3: begin
            stg.a[23:16] = pd[7:0];
            stg.s  = pd[9:8];
            stg.r  = pd[10];
            stg.fc = pd[13:11];
            push   = 1;
          end
          3'd7: clr = !pd[15] && pd[3];
          default: ;
        endcase
      end
    end
    ok = (mq.size() < DEPTH) || pop;
    if (pop) void'(mq.pop_front());
    if (push && ok) mq.push_back(stg);
    if (clr) m_ovf = 0;
    if (push && !ok) m_ovf = 1;
    @(posedge sysclk);
    @(negedge sysclk);
    check_outputs();
  endtask

  task automatic pi_write(input logic [2:0] a, input logic [15:0] d,
                          input int lo, input int hi);
    pi_a = a; pi_d = d; pi_wr = 1'b0;
    repeat (lo) cyc();
    pi_wr = 1'b1;
    repeat (hi) cyc();
  endtask

  task automatic do_reset(input int cycles);
    nreset = 1'b0;
    #1;
    mq.delete();
    stg = '0; m_ovf = 0; pend = 0; prev_wr = pi_wr;
    chk("rst_valid", rq.REQ_VALID, 1'b0);
    chk("rst_count", count, 3'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, in_flight);
    chk("rst_addr", rq.REQ_ADDR, 24'h0);
    repeat (cycles) @(negedge sysclk);
    nreset = 1'b1;
  endtask

  task automatic drain_check(input int first, input int n);
    rdy_mode = 1;
    for (int k = 0; k < n; k++) begin
      chk("drain_valid", rq.REQ_VALID, 1'b1);
      chk("drain_order", rq.REQ_ADDR[23:16], first + k);
      cyc();
    end
    rdy_mode = 0;
    cyc();
  endtask

  initial begin
    int n;
    rq.REQ_READY = 1'b0;
    @(negedge sysclk);
    do_reset(2);
    repeat (4) cyc();

    // Basic request assembly and event-to-valid latency
    pi_write(3'd0, 16'h5678, 3, 3);
    pi_write(3'd1, 16'h1234, 3, 3);
    pi_write(3'd2, 16'hBEEF, 3, 3);
    pi_a = 3'd3; pi_d = 16'h0C12; pi_wr = 1'b0;
    n = 0;
    while (!rq.REQ_VALID && n < 8) begin cyc(); n++; end
    chk("t1_latency", n, 3);
    pi_wr = 1'b1;
    repeat (3) cyc();
    chk("t1_addr", rq.REQ_ADDR, 24'h12BEEF);
    chk("t1_wdata", rq.REQ_WDATA, 32'h12345678);
    chk("t1_size", rq.REQ_SIZE, 2'd0);
    chk("t1_read", rq.REQ_READ, 1'b1);
    chk("t1_fc", rq.REQ_FC, 3'd1);
    chk("t1_count", count, 3'd1);
    rdy_mode = 1; cyc(); rdy_mode = 0; cyc();

    // Fill, overflow, drain order
    for (int i = 1; i <= 4; i++) pi_write(3'd3, 16'(i), 3, 3);
    chk("t2_full", full, 1'b1);
    chk("t2_count", count, 3'd4);
    pi_write(3'd3, 16'h0005, 3, 3);
    chk("t2_ovf", ovf, 1'b1);
    drain_check(1, 4);

    // Overflow clear rules
    pi_write(3'd7, 16'h8008, 3, 3);
    chk("t3_noclr", ovf, 1'b1);
    pi_write(3'd7, 16'h0008, 3, 3);
    chk("t3_clr", ovf, 1'b0);

    // Push into a full FIFO coinciding with a pop
    for (int i = 1; i <= 4; i++) pi_write(3'd3, 16'(i), 3, 3);
    rdy_mode = 3;
    pi_write(3'd3, 16'h0005, 3, 3);
    rdy_mode = 0;
    chk("t4_count", count, 3'd4);
    chk("t4_ovf", ovf, 1'b0);
    drain_check(2, 4);

    // Back-to-back writes with the engine always ready and in flight
    rdy_mode = 1; in_flight = 1'b1; chk_le1 = 1;
    for (int i = 0; i < 8; i++) pi_write(3'd3, 16'h0040 + 16'(i), 3, 3);
    chk("t5_busy", busy, 1'b1);
    chk_le1 = 0; in_flight = 1'b0; rdy_mode = 0;
    cyc();

    // Reset in the middle of a Pi write, released with PI_WR still low
    pi_write(3'd3, 16'h0021, 3, 3);
    pi_write(3'd3, 16'h0022, 3, 3);
    chk("t6_pre_count", count, 3'd2);
    pi_a = 3'd3; pi_d = 16'h0077; pi_wr = 1'b0;
    cyc(); cyc();
    do_reset(3);
    repeat (5) cyc();
    pi_wr = 1'b1;
    repeat (4) cyc();
    chk("t6_count", count, 3'd0);
    chk("t6_valid", rq.REQ_VALID, 1'b0);
    pi_write(3'd0, 16'hAAAA, 3, 3);
    pi_write(3'd1, 16'h5555, 3, 3);
    pi_write(3'd2, 16'h1357, 3, 3);
    pi_write(3'd3, 16'h1F9A, 4, 3);
    chk("t6_addr", rq.REQ_ADDR, 24'h9A1357);
    chk("t6_wdata", rq.REQ_WDATA, 32'h5555AAAA);
    chk("t6_size", rq.REQ_SIZE, 2'd3);
    chk("t6_read", rq.REQ_READ, 1'b1);
    chk("t6_fc", rq.REQ_FC, 3'd3);
    rdy_mode = 1; cyc(); rdy_mode = 0;

    // Randomised traffic
    rand_if = 1;
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [2:0] a;
      r = $urandom_range(0, 9);
      if (r < 7)       a = 3'(r % 4);
      else if (r == 7) a = 3'd7;
      else             a = 3'($urandom_range(4, 6));
      rdy_mode = $urandom_range(0, 2);
      pi_write(a, 16'($urandom), $urandom_range(3, 6), $urandom_range(3, 6));
    end
    rand_if = 0; in_flight = 1'b0; rdy_mode = 1;
    repeat (DEPTH + 2) cyc();
    chk("end_empty", count, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
